msdf_op_arbiter: RTL and testbench
==================================

Name: msdf_op_arbiter

Overview:
- Shares one MSDF digit-serial operator (msdf_add_op / msdf_incr class) among NUM_REQ elastic requester streams.
- Input side: grants one requester at a time and holds the grant for a whole stream, through the digit carrying the last flag. Round-robin between streams.
- Result side: routes the operator's result stream back to the requester that owns it, using an in-order ID FIFO.

Parameters:
- NUM_REQ, 4, number of requester streams (>=2).
- ID_FIFO_DEPTH, 4, maximum number of streams in flight inside the operator (>=1).
- DIGIT_W, 3, digit width; bit 2 = last flag, bits[1:0] = signed digit.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- dataInArray  in  NUM_REQ*DIGIT_W  requester digits; requester i occupies bits [i*3+2:i*3]
- pValidArray  in  NUM_REQ  requester valid
- readyArray  out  NUM_REQ  requester ready
- op_dataOutArray  out  DIGIT_W  digit to the operator
- op_validArray  out  1  valid to the operator
- op_nReadyArray  in  1  operator ready
- res_dataInArray  in  DIGIT_W  result digit from the operator
- res_pValidArray  in  1  result valid
- res_readyArray  out  1  result ready back to the operator
- dataOutArray  out  NUM_REQ*DIGIT_W  result digit to each requester; same value on all lanes
- validArray  out  NUM_REQ  result valid, one-hot or zero
- nReadyArray  in  NUM_REQ  requester result ready
- grant_id  out  clog2(NUM_REQ)  current/last granted requester
- busy  out  1  state == LOCK

Behaviour:
- Reset:
  - Asynchronous on rstn low; also applies mid-stream.
  - State = IDLE; grant_id = 0; rr_ptr = NUM_REQ-1, so requester 0 wins first.
  - ID FIFO empty (head = tail = count = 0).
  - All readyArray, validArray, op_validArray, res_readyArray = 0; busy = 0.
  - A stream aborted by reset is not resumed.
- FSM IDLE:
  - No requester is ready; op_validArray = 0.
  - If any pValidArray bit is set and FIFO count < ID_FIFO_DEPTH: pick the first set bit searching from rr_ptr+1 with wrap-around (NUM_REQ-1 wraps to 0).
  - On a pick: register grant_id, push grant_id into the ID FIFO, go to LOCK.
  - If the FIFO is full: stay in IDLE and grant nothing.
- FSM LOCK:
  - Combinational pass: op_dataOutArray = dataInArray[grant_id]; op_validArray = pValidArray[grant_id]; readyArray[grant_id] = op_nReadyArray; all other ready bits = 0.
  - A handshake (valid & ready) on a digit with bit 2 = 1 moves to IDLE and sets rr_ptr = grant_id.
  - Stream boundary costs exactly one bubble cycle (the IDLE cycle); in-stream throughput is 1 digit/cycle.
  - A stream of a single digit with last set is legal: LOCK lasts 1 cycle.
- Result routing (combinational, zero latency):
  - h = FIFO head.
  - If the FIFO is non-empty: validArray[h] = res_pValidArray; res_readyArray = nReadyArray[h]; dataOutArray lanes = res_dataInArray.
  - If the FIFO is empty: validArray = 0 and res_readyArray = 0. Unexpected results stall; they are never dropped.
  - Pop when a result digit with bit 2 = 1 handshakes.
- Push and pop in the same cycle are allowed: count is unchanged and pointers wrap modulo ID_FIFO_DEPTH.
- Push is gated by the registered count, so it never overflows. Pop is gated by non-empty, so it never underflows.
- The block does not inspect digit values. It never reorders streams; results return in grant order.

Optional Feature:
- Macro: MSDF_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins every IDLE arbitration; rr_ptr is removed.
- Undefined: round-robin as specified above.

Decomposition:
- Package msdf_pkg holds DIGIT_W=3, LAST_BIT=2, and the FSM state encoding (IDLE=1'b0, LOCK=1'b1).
- Sub-module msdf_id_fifo: the ID FIFO.
  - Parameters: width clog2(NUM_REQ), depth ID_FIFO_DEPTH.
  - Signals: push/pop/full/empty/head_data.
  - Async active-low reset.

Test Plan:
- Single requester: requester 2 sends digits 001,011,101 with the operator always ready -> op sees the same 3 digits on consecutive cycles after 1 IDLE cycle; grant_id=2; FIFO count 1. Then operator returns 000,110 -> validArray=4'b0100 on both cycles; FIFO count 0.
- Round-robin with all 4 requesters valid, each sending 2-digit streams -> grant order 0,1,2,3,0. Each stream takes 3 cycles (1 IDLE + 2 LOCK). With MSDF_ARB_FIXED_PRIO_EN defined -> order 0,0,0...
- Backpressure: op_nReadyArray=0 for 3 cycles mid-stream -> readyArray[grant_id]=0 and the digit is held; no other requester is granted during those cycles.
- FIFO full: ID_FIFO_DEPTH=2, requesters 0 and 1 stream with no results returned, requester 3 valid -> stays IDLE with busy=0. Return one result stream ending in last -> requester 3 is granted the next cycle.
- Result with empty FIFO: res_pValidArray=1 at reset exit -> res_readyArray=0 and validArray=0 indefinitely.
- Reset mid-stream: rstn low during LOCK on requester 1 -> next cycle state IDLE, FIFO empty, all outputs 0. After release, requester 0 wins first.

Source files
------------

// File: rtl/msdf_pkg.sv
// Shared constants and FSM encoding for the MSDF operator arbiter.
package msdf_pkg;

  localparam int unsigned DIGIT_W  = 3;
  localparam int unsigned LAST_BIT = 2;

  typedef enum logic {
    StIdle = 1'b0,
    StLock = 1'b1
  } arb_state_e;

endpackage

// File: rtl/msdf_id_fifo.sv
// In-order FIFO of granted requester IDs; the head owns the operator's current result stream.
module msdf_id_fifo #(
  parameter int unsigned Width = 2,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_en, pop_en;

  assign full      = (count_q == CntW'(Depth));
  assign empty     = (count_q == '0);
  assign push_en   = push & ~full;
  assign pop_en    = pop & ~empty;
  assign head_data = mem_q[rd_ptr_q];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_en && !pop_en)      count_q <= count_q + 1'b1;
      else if (!push_en && pop_en) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/msdf_op_arbiter.sv
// Shares one digit-serial MSDF operator among NUM_REQ streams and routes results back in order.
// Define MSDF_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module msdf_op_arbiter
  import msdf_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ID_FIFO_DEPTH = 4,
  localparam int unsigned IdW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ*DIGIT_W-1:0] dataInArray,
  input  logic [NUM_REQ-1:0]         pValidArray,
  output logic [NUM_REQ-1:0]         readyArray,
  output logic [DIGIT_W-1:0]         op_dataOutArray,
  output logic                       op_validArray,
  input  logic                       op_nReadyArray,
  input  logic [DIGIT_W-1:0]         res_dataInArray,
  input  logic                       res_pValidArray,
  output logic                       res_readyArray,
  output logic [NUM_REQ*DIGIT_W-1:0] dataOutArray,
  output logic [NUM_REQ-1:0]         validArray,
  input  logic [NUM_REQ-1:0]         nReadyArray,
  output logic [IdW-1:0]             grant_id,
  output logic                       busy
);

  arb_state_e       state_q, state_d;
  logic [IdW-1:0]   grant_id_q, grant_id_d;
  logic             pick_valid;
  logic [IdW-1:0]   pick_id;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IdW-1:0]   head_id;
  logic [DIGIT_W-1:0] in_digit [NUM_REQ];

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_lane
    assign in_digit[g] = dataInArray[g*DIGIT_W +: DIGIT_W];
  end

`ifdef MSDF_ARB_FIXED_PRIO_EN
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    // Descending scan so the lowest valid index is written last.
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (pValidArray[IdW'(i)]) begin
        pick_valid = 1'b1;
        pick_id    = IdW'(i);
      end
    end
  end
`else
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    int unsigned idx;
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!pick_valid && pValidArray[IdW'(idx)]) begin
        pick_valid = 1'b1;
        pick_id    = IdW'(idx);
      end
    end
  end
`endif

  always_comb begin
    state_d         = state_q;
    grant_id_d      = grant_id_q;
`ifndef MSDF_ARB_FIXED_PRIO_EN
    rr_ptr_d        = rr_ptr_q;
`endif
    fifo_push       = 1'b0;
    readyArray      = '0;
    op_dataOutArray = '0;
    op_validArray   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid && !fifo_full) begin
          fifo_push  = 1'b1;
          grant_id_d = pick_id;
          state_d    = StLock;
        end
      end
      StLock: begin
        op_dataOutArray        = in_digit[grant_id_q];
        op_validArray          = pValidArray[grant_id_q];
        readyArray[grant_id_q] = op_nReadyArray;
        if (op_validArray && op_nReadyArray && op_dataOutArray[LAST_BIT]) begin
          state_d = StIdle;
`ifndef MSDF_ARB_FIXED_PRIO_EN
          rr_ptr_d = grant_id_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Results belong to the oldest outstanding stream; with none outstanding they stall.
  always_comb begin
    validArray     = '0;
    res_readyArray = 1'b0;
    dataOutArray   = '0;
    fifo_pop       = 1'b0;
    if (!fifo_empty) begin
      validArray[head_id] = res_pValidArray;
      res_readyArray      = nReadyArray[head_id];
      dataOutArray        = {NUM_REQ{res_dataInArray}};
      fifo_pop            = res_pValidArray & res_readyArray & res_dataInArray[LAST_BIT];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      grant_id_q <= '0;
`ifndef MSDF_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= IdW'(NUM_REQ - 1);
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
`ifndef MSDF_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  msdf_id_fifo #(
    .Width (IdW),
    .Depth (ID_FIFO_DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data (pick_id),
    .pop       (fifo_pop),
    .head_data (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign grant_id = grant_id_q;
  assign busy     = (state_q == StLock);

endmodule

// File: tb/tb_msdf_op_arbiter.sv
// Directed self-checking bench for msdf_op_arbiter (4 requesters, ID FIFO depth 2).
module tb_msdf_op_arbiter;

  localparam int NR = 4;
  localparam int DW = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NR*DW-1:0] dataInArray;
  logic [NR-1:0]    pValidArray;
  logic [NR-1:0]    readyArray;
  logic [DW-1:0]    op_dataOutArray;
  logic             op_validArray;
  logic             op_nReadyArray;
  logic [DW-1:0]    res_dataInArray;
  logic             res_pValidArray;
  logic             res_readyArray;
  logic [NR*DW-1:0] dataOutArray;
  logic [NR-1:0]    validArray;
  logic [NR-1:0]    nReadyArray;
  logic [1:0]       grant_id;
  logic             busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  msdf_op_arbiter #(
    .NUM_REQ       (NR),
    .ID_FIFO_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .dataInArray     (dataInArray),
    .pValidArray     (pValidArray),
    .readyArray      (readyArray),
    .op_dataOutArray (op_dataOutArray),
    .op_validArray   (op_validArray),
    .op_nReadyArray  (op_nReadyArray),
    .res_dataInArray (res_dataInArray),
    .res_pValidArray (res_pValidArray),
    .res_readyArray  (res_readyArray),
    .dataOutArray    (dataOutArray),
    .validArray      (validArray),
    .nReadyArray     (nReadyArray),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Lane l carries d; other lanes carry a non-last filler digit.
  task automatic set_lane(input int l, input logic [2:0] d);
    dataInArray = {NR{3'b011}};
    dataInArray[l*DW +: DW] = d;
  endtask

  function automatic logic [NR*DW-1:0] lanes(input logic [2:0] d);
    return {NR{d}};
  endfunction

  int exp_order [5];
  int exp_bp2;
  int exp_after_reset;

  initial begin
`ifdef MSDF_ARB_FIXED_PRIO_EN
    exp_order       = '{0, 0, 0, 0, 0};
    exp_bp2         = 1;
    exp_after_reset = 0;
`else
    exp_order       = '{0, 1, 2, 3, 0};
    exp_bp2         = 2;
    exp_after_reset = 1;
`endif
    rstn            = 1'b0;
    pValidArray     = '0;
    dataInArray     = '0;
    op_nReadyArray  = 1'b1;
    res_dataInArray = 3'b000;
    res_pValidArray = 1'b1;
    nReadyArray     = 4'hF;

    // Reset state
    #12;
    chk("rst_ready", 32'(readyArray), 0);
    chk("rst_valid", 32'(validArray), 0);
    chk("rst_op_valid", 32'(op_validArray), 0);
    chk("rst_res_ready", 32'(res_readyArray), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Result arriving with no outstanding stream stalls
    tick();
    tick();
    settle();
    chk("empty_res_ready", 32'(res_readyArray), 0);
    chk("empty_valid", 32'(validArray), 0);
    res_pValidArray = 1'b0;

    // Single requester 2, three digits
    pValidArray = 4'b0100;
    set_lane(2, 3'b001);
    settle();
    chk("s_idle_busy", 32'(busy), 0);
    chk("s_idle_op_valid", 32'(op_validArray), 0);
    chk("s_idle_ready", 32'(readyArray), 0);
    tick();
    settle();
    chk("s_busy", 32'(busy), 1);
    chk("s_grant", 32'(grant_id), 2);
    chk("s_op_valid", 32'(op_validArray), 1);
    chk("s_op_d0", 32'(op_dataOutArray), 32'b001);
    chk("s_ready", 32'(readyArray), 32'b0100);
    tick();
    set_lane(2, 3'b011);
    settle();
    chk("s_op_d1", 32'(op_dataOutArray), 32'b011);
    tick();
    set_lane(2, 3'b101);
    settle();
    chk("s_op_d2", 32'(op_dataOutArray), 32'b101);
    chk("s_ready_d2", 32'(readyArray), 32'b0100);
    tick();
    pValidArray = '0;
    settle();
    chk("s_back_idle", 32'(busy), 0);
    chk("s_idle_op_valid2", 32'(op_validArray), 0);
    res_pValidArray = 1'b1;
    res_dataInArray = 3'b000;
    settle();
    chk("s_res_valid0", 32'(validArray), 32'b0100);
    chk("s_res_ready0", 32'(res_readyArray), 1);
    tick();
    res_dataInArray = 3'b110;
    settle();
    chk("s_res_valid1", 32'(validArray), 32'b0100);
    chk("s_res_data1", 32'(dataOutArray), 32'hDB6);
    tick();
    settle();
    chk("s_popped_valid", 32'(validArray), 0);
    chk("s_popped_ready", 32'(res_readyArray), 0);
    res_pValidArray = 1'b0;

    // Round-robin from reset, all requesters valid, 2-digit streams, results drained
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    res_pValidArray = 1'b1;
    res_dataInArray = 3'b100;
    pValidArray     = 4'hF;
    for (int s = 0; s < 5; s++) begin
      dataInArray = lanes(3'b001);
      settle();
      chk("rr_idle_busy", 32'(busy), 0);
      tick();
      settle();
      chk("rr_grant", 32'(grant_id), 32'(exp_order[s]));
      chk("rr_ready", 32'(readyArray), 32'(1 << exp_order[s]));
      chk("rr_res_valid", 32'(validArray), 32'(1 << exp_order[s]));
      tick();
      dataInArray = lanes(3'b100);
      settle();
      chk("rr_op_last", 32'(op_dataOutArray), 32'b100);
      chk("rr_res_drained", 32'(validArray), 0);
      tick();
    end
    pValidArray     = '0;
    res_pValidArray = 1'b0;

    // Backpressure mid-stream on requester 1, requester 2 also waiting
    pValidArray = 4'b0110;
    dataInArray = lanes(3'b001);
    settle();
    chk("bp_idle_busy", 32'(busy), 0);
    tick();
    settle();
    chk("bp_grant", 32'(grant_id), 1);
    chk("bp_ready", 32'(readyArray), 32'b0010);
    tick();
    op_nReadyArray = 1'b0;
    dataInArray    = lanes(3'b110);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_stall_ready", 32'(readyArray), 0);
      chk("bp_stall_valid", 32'(op_validArray), 1);
      chk("bp_stall_data", 32'(op_dataOutArray), 32'b110);
      chk("bp_stall_grant", 32'(grant_id), 1);
      chk("bp_stall_busy", 32'(busy), 1);
      tick();
    end
    op_nReadyArray = 1'b1;
    settle();
    chk("bp_release_ready", 32'(readyArray), 32'b0010);
    tick();
    settle();
    chk("bp_bubble", 32'(busy), 0);
    tick();
    settle();
    chk("bp_next_grant", 32'(grant_id), 32'(exp_bp2));
    dataInArray = lanes(3'b100);
    tick();
    pValidArray = 4'b1000;

    // ID FIFO full (two streams outstanding): requester 3 must wait
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("full_busy", 32'(busy), 0);
      chk("full_ready", 32'(readyArray), 0);
      chk("full_op_valid", 32'(op_validArray), 0);
      tick();
    end
    res_pValidArray = 1'b1;
    res_dataInArray = 3'b000;
    settle();
    chk("full_res_valid0", 32'(validArray), 32'b0010);
    tick();
    res_dataInArray = 3'b100;
    settle();
    chk("full_res_valid1", 32'(validArray), 32'b0010);
    chk("full_res_ready1", 32'(res_readyArray), 1);
    tick();
    res_pValidArray = 1'b0;
    settle();
    chk("full_pick_idle", 32'(busy), 0);
    tick();
    settle();
    chk("full_grant_busy", 32'(busy), 1);
    chk("full_grant3", 32'(grant_id), 3);

    // Reset while streaming
    res_dataInArray = 3'b000;
    dataInArray     = lanes(3'b001);
    rstn            = 1'b0;
    res_pValidArray = 1'b1;
    settle();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(readyArray), 0);
    chk("mid_rst_op_valid", 32'(op_validArray), 0);
    chk("mid_rst_valid", 32'(validArray), 0);
    chk("mid_rst_res_ready", 32'(res_readyArray), 0);
    chk("mid_rst_grant", 32'(grant_id), 0);
    tick();
    rstn            = 1'b1;
    pValidArray     = 4'b1011;
    dataInArray     = lanes(3'b100);
    res_dataInArray = 3'b100;
    settle();
    chk("post_rst_idle", 32'(busy), 0);
    chk("post_rst_res_ready", 32'(res_readyArray), 0);
    tick();
    settle();
    chk("post_rst_grant0", 32'(grant_id), 0);
    chk("post_rst_busy", 32'(busy), 1);
    chk("post_rst_ready", 32'(readyArray), 32'b0001);
    chk("post_rst_res_valid", 32'(validArray), 32'b0001);
    tick();
    settle();
    chk("single_digit_idle", 32'(busy), 0);
    tick();
    settle();
    chk("single_digit_next", 32'(grant_id), 32'(exp_after_reset));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
